icache_tag_port_arbiter: RTL and testbench
==========================================

Name: icache_tag_port_arbiter

Overview:
- Shares the single-port L1I tag memory (tag query stage) between two requesters: fetch lookups and refill tag updates.
- Guarantees fetchEnable and updateEnable are never asserted together, and zeroes the unused index/tag field of the inactive side.
- Buffers refill updates in a 2-entry FIFO.
- Bounds update starvation and blocks fetch lookups that would read an index with a pending update.

Parameters:
- offsetSize, 5, byte-offset bits
- indexSize, 8, index bits
- tagSize, 64-(offsetSize+indexSize), tag bits
- starveLimit, 4, consecutive cycles a pending update may lose arbitration before it is forced

Ports:
- clock_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- flushPipeline_i  in  1  pipeline flush
- tagQueryStall_i  in  1  tag stage stall
- fetchUnitStall_i  in  1  fetch unit stall
- fetchReq_i  in  1  fetch lookup valid
- fetchTag_i  in  tagSize  lookup tag
- fetchIndex_i  in  indexSize  lookup index
- fetchOffset_i  in  offsetSize  lookup offset
- fetchAccept_o  out  1  lookup accepted this cycle (combinational)
- updateReq_i  in  1  refill update valid
- updateTag_i  in  tagSize  new tag
- updateIndex_i  in  indexSize  new index
- updateReady_o  out  1  FIFO not full (registered)
- fetchEnable_o  out  1  to tag query fetchEnable_i
- updateEnable_o  out  1  to tag query updateEnable_i
- tag_o  out  tagSize  to tag_i
- index_o  out  indexSize  to index_i
- offset_o  out  offsetSize  to offset_i
- newTag_o  out  tagSize  to newTag_i
- newIndex_o  out  indexSize  to newIndex_i
- hazard_o  out  1  fetch blocked by index match this cycle (combinational)

Behaviour:
- Reset (clock_i edge with reset_i=1):
  - FIFO emptied.
  - Starvation counter = 0.
  - All registered outputs = 0.
  - updateReady_o = 1.
- FIFO:
  - 2 entries of {tag, index}, in-order.
  - Push when updateReq_i && updateReady_o.
  - updateReady_o = !full, computed from the registered count. No push while full, even if a pop happens in the same cycle.
  - No bypass: a pushed entry is eligible for arbitration from the next cycle.
  - Push and pop in the same cycle leave the count unchanged.
- Hazard:
  - hazard_o = fetchReq_i && some valid FIFO entry's index == fetchIndex_i.
- fetchOK = fetchReq_i && !tagQueryStall_i && !fetchUnitStall_i && !flushPipeline_i && !hazard_o.
- Arbitration, evaluated each cycle:
  - forceUpd = FIFO full || hazard_o || starveCnt == starveLimit.
  - If FIFO non-empty && (forceUpd || !fetchOK): grant update. Pop the head; starveCnt <= 0.
  - Else if fetchOK: grant fetch. fetchAccept_o = 1. If FIFO non-empty, starveCnt <= starveCnt+1, saturating at starveLimit.
  - Else: idle. starveCnt holds.
  - fetchAccept_o = 1 only on a fetch grant. The requester holds its inputs until accepted.
- Output register, updated on the edge after the grant (1-cycle latency, request at N -> enable at N+1):
  - Fetch grant: fetchEnable_o=1, updateEnable_o=0, tag/index/offset_o = fetch inputs, newTag_o = newIndex_o = 0.
  - Update grant: updateEnable_o=1, fetchEnable_o=0, newTag/newIndex_o = FIFO head, tag/index/offset_o = 0.
  - Idle: both enables = 0, all fields = 0.
- Flush:
  - Blocks fetch grants in the flush cycle.
  - Forces fetchEnable_o=0 on the following edge.
  - Does not drop FIFO contents; updates may still be granted during flush.
- Stalls gate fetch only; updates proceed during stalls.
- Invariant: fetchEnable_o && updateEnable_o is never 1. newIndex_o == 0 whenever fetchEnable_o; index_o == 0 whenever updateEnable_o.
- Reset mid-operation: pending updates are discarded (the refill unit re-issues); outputs = 0 on the next edge.

Test Plan:
- Reset, then fetchReq_i=1, index 0x12, tag 0x5, no updates -> fetchAccept_o=1 at N; at N+1 fetchEnable_o=1, index_o=0x12, tag_o=0x5, newIndex_o=0, updateEnable_o=0.
- Continuous fetch to index 0x01; one update (index 0x40) pushed at N -> fetch wins while starveCnt<4; update issued with updateEnable_o=1, newIndex_o=0x40 exactly 4 fetch grants after the push; starveCnt returns to 0.
- Update index 0x33 pending; fetchReq_i with index 0x33 -> hazard_o=1, fetchAccept_o=0; update issued next; fetch accepted the cycle after the FIFO no longer holds 0x33.
- Push 2 updates with fetch active -> updateReady_o=0; the full FIFO forces an update grant over fetch; updateReady_o=1 after the pop.
- tagQueryStall_i=1 with fetchReq_i=1 and 1 pending update -> fetchAccept_o=0, update drains, fetchEnable_o stays 0. flushPipeline_i=1 for 1 cycle -> no fetch grant that cycle; FIFO count unchanged.
- Reset asserted with 2 pending updates -> next edge: all outputs 0, updateReady_o=1, no further updateEnable_o. A random-stimulus check confirms the mutual-exclusion invariant across all tests.

Source files
------------

// File: rtl/icache_tag_port_arbiter.sv
// Arbitrates the single-port L1I tag query stage between fetch lookups and
// buffered refill tag updates, with bounded update starvation and index hazards.
module icache_tag_port_arbiter #(
  parameter int unsigned offsetSize  = 5,
  parameter int unsigned indexSize   = 8,
  parameter int unsigned tagSize     = 64 - (offsetSize + indexSize),
  parameter int unsigned starveLimit = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  flushPipeline_i,
  input  logic                  tagQueryStall_i,
  input  logic                  fetchUnitStall_i,
  input  logic                  fetchReq_i,
  input  logic [tagSize-1:0]    fetchTag_i,
  input  logic [indexSize-1:0]  fetchIndex_i,
  input  logic [offsetSize-1:0] fetchOffset_i,
  output logic                  fetchAccept_o,
  input  logic                  updateReq_i,
  input  logic [tagSize-1:0]    updateTag_i,
  input  logic [indexSize-1:0]  updateIndex_i,
  output logic                  updateReady_o,
  output logic                  fetchEnable_o,
  output logic                  updateEnable_o,
  output logic [tagSize-1:0]    tag_o,
  output logic [indexSize-1:0]  index_o,
  output logic [offsetSize-1:0] offset_o,
  output logic [tagSize-1:0]    newTag_o,
  output logic [indexSize-1:0]  newIndex_o,
  output logic                  hazard_o
);

  localparam int unsigned CntW = $clog2(starveLimit + 1);

  logic [tagSize-1:0]   fifo_tag_q [2];
  logic [indexSize-1:0] fifo_idx_q [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           count_q, count_d;
  logic [CntW-1:0]      starve_q, starve_d;

  logic fifo_empty, fifo_full, push, idx_match;
  logic fetch_ok, force_upd, grant_upd, grant_fetch;

  assign fifo_empty    = (count_q == 2'd0);
  assign fifo_full     = (count_q == 2'd2);
  assign updateReady_o = !fifo_full;
  assign push          = updateReq_i && !fifo_full;

  // Only entries already stored are compared; a same-cycle push is not visible yet.
  assign idx_match = (!fifo_empty && (fifo_idx_q[rd_ptr_q] == fetchIndex_i)) ||
                     (fifo_full && (fifo_idx_q[~rd_ptr_q] == fetchIndex_i));
  assign hazard_o  = fetchReq_i && idx_match;

  assign fetch_ok    = fetchReq_i && !tagQueryStall_i && !fetchUnitStall_i &&
                       !flushPipeline_i && !hazard_o;
  assign force_upd   = fifo_full || hazard_o || (starve_q == CntW'(starveLimit));
  assign grant_upd   = !fifo_empty && (force_upd || !fetch_ok);
  assign grant_fetch = !grant_upd && fetch_ok;

  assign fetchAccept_o = grant_fetch;

  always_comb begin
    count_d  = count_q;
    starve_d = starve_q;
    unique case ({push, grant_upd})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (grant_upd) begin
      starve_d = '0;
    end else if (grant_fetch && !fifo_empty && (starve_q != CntW'(starveLimit))) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fifo_tag_q[0]  <= '0;
      fifo_tag_q[1]  <= '0;
      fifo_idx_q[0]  <= '0;
      fifo_idx_q[1]  <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= '0;
      starve_q       <= '0;
      fetchEnable_o  <= 1'b0;
      updateEnable_o <= 1'b0;
      tag_o          <= '0;
      index_o        <= '0;
      offset_o       <= '0;
      newTag_o       <= '0;
      newIndex_o     <= '0;
    end else begin
      if (push) begin
        fifo_tag_q[wr_ptr_q] <= updateTag_i;
        fifo_idx_q[wr_ptr_q] <= updateIndex_i;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (grant_upd) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q  <= count_d;
      starve_q <= starve_d;

      // Inactive side's fields are always zeroed.
      fetchEnable_o  <= grant_fetch;
      updateEnable_o <= grant_upd;
      tag_o          <= grant_fetch ? fetchTag_i    : '0;
      index_o        <= grant_fetch ? fetchIndex_i  : '0;
      offset_o       <= grant_fetch ? fetchOffset_i : '0;
      newTag_o       <= grant_upd ? fifo_tag_q[rd_ptr_q] : '0;
      newIndex_o     <= grant_upd ? fifo_idx_q[rd_ptr_q] : '0;
    end
  end

endmodule

// File: tb/tb_icache_tag_port_arbiter.sv
// Directed bench for icache_tag_port_arbiter with a running invariant monitor
// and a short randomized phase.
module tb_icache_tag_port_arbiter;

  localparam int unsigned OffW = 5;
  localparam int unsigned IdxW = 8;
  localparam int unsigned TagW = 64 - (OffW + IdxW);

  logic            clock = 1'b0;
  logic            reset;
  logic            flush, tq_stall, fu_stall;
  logic            fetch_req;
  logic [TagW-1:0] fetch_tag;
  logic [IdxW-1:0] fetch_idx;
  logic [OffW-1:0] fetch_off;
  logic            fetch_accept;
  logic            upd_req;
  logic [TagW-1:0] upd_tag;
  logic [IdxW-1:0] upd_idx;
  logic            upd_ready;
  logic            fe, ue;
  logic [TagW-1:0] tag_out, new_tag;
  logic [IdxW-1:0] idx_out, new_idx;
  logic [OffW-1:0] off_out;
  logic            hazard;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  icache_tag_port_arbiter dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .flushPipeline_i  (flush),
    .tagQueryStall_i  (tq_stall),
    .fetchUnitStall_i (fu_stall),
    .fetchReq_i       (fetch_req),
    .fetchTag_i       (fetch_tag),
    .fetchIndex_i     (fetch_idx),
    .fetchOffset_i    (fetch_off),
    .fetchAccept_o    (fetch_accept),
    .updateReq_i      (upd_req),
    .updateTag_i      (upd_tag),
    .updateIndex_i    (upd_idx),
    .updateReady_o    (upd_ready),
    .fetchEnable_o    (fe),
    .updateEnable_o   (ue),
    .tag_o            (tag_out),
    .index_o          (idx_out),
    .offset_o         (off_out),
    .newTag_o         (new_tag),
    .newIndex_o       (new_idx),
    .hazard_o         (hazard)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Invariants on the registered tag-stage interface, checked every cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      check("mutex", 64'(fe && ue), 64'd0);
      if (fe) check("fe_newidx_zero", 64'(new_idx), 64'd0);
      if (ue) check("ue_idx_zero", 64'(idx_out), 64'd0);
      if (hazard) check("hazard_no_accept", 64'(fetch_accept), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Push one update under continuous fetch and count fetch grants until it issues.
  task automatic starve_run(input logic [IdxW-1:0] uidx, input logic [TagW-1:0] utag);
    int nf = 0;
    bit got = 1'b0;
    upd_req = 1'b1;
    upd_idx = uidx;
    upd_tag = utag;
    #1;
    check("starve_push_accept", 64'(fetch_accept), 64'd1);
    tick();
    upd_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (fetch_accept) nf++;
      tick();
      if (ue) begin
        got = 1'b1;
        break;
      end
    end
    check("starve_issued", 64'(got), 64'd1);
    check("starve_fetch_grants", 64'(nf), 64'd4);
    check("starve_new_idx", 64'(new_idx), 64'(uidx));
    check("starve_new_tag", 64'(new_tag), 64'(utag));
    check("starve_fe_off", 64'(fe), 64'd0);
  endtask

  initial begin
    int n_ue;
    reset = 1'b1;
    flush = 1'b0; tq_stall = 1'b0; fu_stall = 1'b0;
    fetch_req = 1'b0; fetch_tag = '0; fetch_idx = '0; fetch_off = '0;
    upd_req = 1'b0; upd_tag = '0; upd_idx = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_fe", 64'(fe), 64'd0);
    check("rst_ue", 64'(ue), 64'd0);
    check("rst_ready", 64'(upd_ready), 64'd1);
    check("rst_idx", 64'(idx_out), 64'd0);
    check("rst_new_idx", 64'(new_idx), 64'd0);
    mon_en = 1'b1;

    // Plain fetch lookup, one-cycle latency.
    fetch_req = 1'b1; fetch_idx = 8'h12; fetch_tag = 51'h5; fetch_off = 5'h3;
    #1;
    check("f_accept", 64'(fetch_accept), 64'd1);
    check("f_hazard", 64'(hazard), 64'd0);
    tick();
    check("f_fe", 64'(fe), 64'd1);
    check("f_idx", 64'(idx_out), 64'h12);
    check("f_tag", 64'(tag_out), 64'h5);
    check("f_off", 64'(off_out), 64'h3);
    check("f_new_idx", 64'(new_idx), 64'd0);
    check("f_ue", 64'(ue), 64'd0);
    fetch_req = 1'b0;
    tick();
    check("idle_fe", 64'(fe), 64'd0);
    check("idle_tag", 64'(tag_out), 64'd0);

    // Starvation bound; the second run shows the counter was cleared.
    fetch_req = 1'b1; fetch_idx = 8'h01; fetch_tag = 51'hA; fetch_off = 5'h0;
    starve_run(8'h40, 51'h77);
    starve_run(8'h41, 51'h78);
    fetch_req = 1'b0;
    tick();

    // Index hazard against a pending update.
    upd_req = 1'b1; upd_idx = 8'h33; upd_tag = 51'h99;
    tick();
    upd_req = 1'b0;
    fetch_req = 1'b1; fetch_idx = 8'h33; fetch_tag = 51'h1;
    #1;
    check("hz_hazard", 64'(hazard), 64'd1);
    check("hz_accept", 64'(fetch_accept), 64'd0);
    tick();
    check("hz_ue", 64'(ue), 64'd1);
    check("hz_new_idx", 64'(new_idx), 64'h33);
    check("hz_fe", 64'(fe), 64'd0);
    #1;
    check("hz_clear", 64'(hazard), 64'd0);
    check("hz_accept_after", 64'(fetch_accept), 64'd1);
    tick();
    check("hz_fe_after", 64'(fe), 64'd1);
    check("hz_idx_after", 64'(idx_out), 64'h33);
    fetch_req = 1'b0;
    tick();

    // Full FIFO forces an update; no push while full even with a pop.
    fetch_req = 1'b1; fetch_idx = 8'h01;
    upd_req = 1'b1; upd_idx = 8'h50; upd_tag = 51'h1;
    #1;
    check("full_ready0", 64'(upd_ready), 64'd1);
    check("full_accept0", 64'(fetch_accept), 64'd1);
    tick();
    upd_idx = 8'h51; upd_tag = 51'h2;
    #1;
    check("full_ready1", 64'(upd_ready), 64'd1);
    check("full_accept1", 64'(fetch_accept), 64'd1);
    tick();
    upd_idx = 8'h52; upd_tag = 51'h3;
    #1;
    check("full_ready2", 64'(upd_ready), 64'd0);
    check("full_accept2", 64'(fetch_accept), 64'd0);
    tick();
    check("full_ue", 64'(ue), 64'd1);
    check("full_new_idx", 64'(new_idx), 64'h50);
    check("full_fe", 64'(fe), 64'd0);
    upd_req = 1'b0; fetch_req = 1'b0;
    check("full_ready_after_pop", 64'(upd_ready), 64'd1);
    tick();
    check("full_ue2", 64'(ue), 64'd1);
    check("full_new_idx2", 64'(new_idx), 64'h51);
    tick();
    check("full_drained_ue", 64'(ue), 64'd0);
    check("full_drained_ready", 64'(upd_ready), 64'd1);

    // Stall gates fetch but the update still drains.
    fetch_req = 1'b1; fetch_idx = 8'h02; tq_stall = 1'b1;
    upd_req = 1'b1; upd_idx = 8'h60; upd_tag = 51'h6;
    #1;
    check("st_accept0", 64'(fetch_accept), 64'd0);
    tick();
    check("st_fe0", 64'(fe), 64'd0);
    check("st_ue0", 64'(ue), 64'd0);
    upd_req = 1'b0;
    #1;
    check("st_accept1", 64'(fetch_accept), 64'd0);
    tick();
    check("st_ue1", 64'(ue), 64'd1);
    check("st_new_idx", 64'(new_idx), 64'h60);
    check("st_fe1", 64'(fe), 64'd0);
    tick();
    check("st_fe2", 64'(fe), 64'd0);
    check("st_ue2", 64'(ue), 64'd0);
    tq_stall = 1'b0;

    // Flush blocks the fetch grant but keeps the pushed update.
    fetch_idx = 8'h03; flush = 1'b1;
    upd_req = 1'b1; upd_idx = 8'h70; upd_tag = 51'h7;
    #1;
    check("fl_accept", 64'(fetch_accept), 64'd0);
    tick();
    check("fl_fe", 64'(fe), 64'd0);
    check("fl_ue", 64'(ue), 64'd0);
    flush = 1'b0; upd_req = 1'b0;
    #1;
    check("fl_accept_after", 64'(fetch_accept), 64'd1);
    tick();
    check("fl_fe_after", 64'(fe), 64'd1);
    check("fl_idx_after", 64'(idx_out), 64'h03);
    fetch_req = 1'b0;
    tick();
    check("fl_kept_ue", 64'(ue), 64'd1);
    check("fl_kept_idx", 64'(new_idx), 64'h70);
    tick();

    // Reset with two pending updates discards them.
    fetch_req = 1'b1; fetch_idx = 8'h04;
    upd_req = 1'b1; upd_idx = 8'h80; upd_tag = 51'h8;
    tick();
    upd_idx = 8'h81; upd_tag = 51'h9;
    tick();
    upd_req = 1'b0; fetch_req = 1'b0; reset = 1'b1;
    #1;
    check("rr_ready_full", 64'(upd_ready), 64'd0);
    tick();
    reset = 1'b0;
    check("rr_fe", 64'(fe), 64'd0);
    check("rr_ue", 64'(ue), 64'd0);
    check("rr_tag", 64'(tag_out), 64'd0);
    check("rr_idx", 64'(idx_out), 64'd0);
    check("rr_new_tag", 64'(new_tag), 64'd0);
    check("rr_new_idx", 64'(new_idx), 64'd0);
    check("rr_ready", 64'(upd_ready), 64'd1);
    n_ue = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ue) n_ue++;
    end
    check("rr_no_update", 64'(n_ue), 64'd0);

    // Random traffic with a small index space; the monitor checks invariants.
    for (int k = 0; k < 400; k++) begin
      fetch_req = 1'($urandom_range(0, 1));
      fetch_idx = 8'($urandom_range(0, 3));
      fetch_tag = 51'($urandom);
      fetch_off = 5'($urandom);
      upd_req   = 1'($urandom_range(0, 1));
      upd_idx   = 8'($urandom_range(0, 3));
      upd_tag   = 51'($urandom);
      tq_stall  = ($urandom_range(0, 7) == 0);
      fu_stall  = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    fetch_req = 1'b0; upd_req = 1'b0; tq_stall = 1'b0; fu_stall = 1'b0; flush = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("rand_drained_ready", 64'(upd_ready), 64'd1);
    check("rand_drained_ue", 64'(ue), 64'd0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
